// File: rtl/sync_pkg.sv
// ============================================================================
//  Module   : sync_pkg
//  Purpose  : Shared constants and helpers for the sync_pipe_ff pipeline.
//             - SYNC_PIPE_MAX_DEPTH : largest supported stage count
//             - occ_w()             : width of the occupancy counter
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_pkg;

  localparam int SYNC_PIPE_MAX_DEPTH = 64;

  // Bits needed to count 0..depth; never narrower than one bit.
  function automatic int occ_w(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_pipe_stage.sv
// ============================================================================
//  Module   : sync_pipe_stage
//  Purpose  : One elastic register stage (valid + data) of sync_pipe_ff.
//             Loads from its source whenever it is empty or the next stage
//             can take its current word; holds otherwise. FLUSH clears the
//             valid bit while leaving the data untouched.
//  Ports    : CLK, RESET_N      clock, async active-low reset
//             flush_i          synchronous discard
//             src_valid_i/src_data_i  upstream word
//             rdy_in_i         downstream stage (or sink) can accept
//             valid_o/data_o   stored word
//             rdy_out_o        this stage can accept from upstream
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_pipe_stage
  import sync_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              flush_i,
  input  logic              src_valid_i,
  input  logic [DATA_W-1:0] src_data_i,
  input  logic              rdy_in_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              rdy_out_o
);

  logic              v_q, v_d;
  logic [DATA_W-1:0] d_q, d_d;

  // An empty stage is always free, so bubbles get squeezed out under stall.
  assign rdy_out_o = !v_q || rdy_in_i;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush_i) begin
      v_d = 1'b0;
    end else if (rdy_out_o) begin
      v_d = src_valid_i;
      // Data only moves with a real word; bubbles leave it untouched.
      if (src_valid_i) begin
        d_d = src_data_i;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign valid_o = v_q;
  assign data_o  = d_q;

endmodule

`default_nettype wire

// File: rtl/sync_pipe_ff.sv
// ============================================================================
//  Module   : sync_pipe_ff
//  Purpose  : DEPTH-stage elastic register pipeline with valid/ready flow
//             control and synchronous FLUSH. Latency DEPTH cycles, one word
//             per cycle sustained, empty stages collapse under backpressure.
//  Ports    : CLK, RESET_N           clock, async active-low reset
//             DIN/DIN_VALID/DIN_READY     upstream handshake
//             DOUT/DOUT_VALID/DOUT_READY  downstream handshake
//             FLUSH                  discard all stored words next cycle
//             OCC                    stage occupancy (optional)
//  Options  : SYNC_PIPE_FF_OCC_EN - adds the OCC port and its counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_pipe_ff
  import sync_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  input  logic              FLUSH
`ifdef SYNC_PIPE_FF_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0] OCC
`endif
);

  if (DEPTH < 1 || DEPTH > SYNC_PIPE_MAX_DEPTH) begin : g_depth_check
    $error("sync_pipe_ff: DEPTH must be within 1..64");
  end

  // w_rdy[i] : stage i can accept; w_rdy[DEPTH] is the downstream sink.
  logic [DEPTH:0]    w_rdy;
  logic [DEPTH-1:0]  w_v;
  logic [DEPTH-1:0]  w_src_v;
  logic [DATA_W-1:0] w_d     [DEPTH];
  logic [DATA_W-1:0] w_src_d [DEPTH];

  assign w_rdy[DEPTH] = DOUT_READY;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign w_src_v[i] = DIN_VALID;
      assign w_src_d[i] = DIN;
    end else begin : g_body
      assign w_src_v[i] = w_v[i-1];
      assign w_src_d[i] = w_d[i-1];
    end

    sync_pipe_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .flush_i     (FLUSH),
      .src_valid_i (w_src_v[i]),
      .src_data_i  (w_src_d[i]),
      .rdy_in_i    (w_rdy[i+1]),
      .valid_o     (w_v[i]),
      .data_o      (w_d[i]),
      .rdy_out_o   (w_rdy[i])
    );
  end

  // FLUSH wins over any transfer, so nothing is accepted while it is high.
  assign DIN_READY  = w_rdy[0] && !FLUSH;
  assign DOUT       = w_d[DEPTH-1];
  assign DOUT_VALID = w_v[DEPTH-1];

`ifdef SYNC_PIPE_FF_OCC_EN
  localparam int OCC_W = occ_w(DEPTH);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             w_push, w_pop;

  assign w_push = DIN_VALID && DIN_READY;
  assign w_pop  = DOUT_VALID && DOUT_READY;

  always_comb begin
    occ_d = occ_q;
    if (FLUSH) begin
      occ_d = '0;
    end else if (w_push && !w_pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!w_push && w_pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign OCC = occ_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_pipe_ff.sv
// ============================================================================
//  Module   : tb_sync_pipe_ff
//  Purpose  : Self-checking bench for sync_pipe_ff. Two instances (DEPTH=2 and
//             DEPTH=4) share clock and reset; expected output words are
//             queued as stimulus is issued and popped by per-instance
//             monitors on every DOUT handshake.
//  Options  : SYNC_PIPE_FF_OCC_EN - also checks the OCC port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_pipe_ff;

  logic        clk;
  logic        rst_n;

  logic [31:0] din2, dout2, din4, dout4;
  logic        dvi2, drdy2, dvo2, dr2, fl2;
  logic        dvi4, drdy4, dvo4, dr4, fl4;
`ifdef SYNC_PIPE_FF_OCC_EN
  logic [1:0]  occ2;
  logic [2:0]  occ4;
`endif

  int          tests = 0;
  int          fails = 0;
  logic [31:0] q2[$];
  logic [31:0] q4[$];

  sync_pipe_ff #(.DATA_W(32), .DEPTH(2)) u_dut2 (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .DIN        (din2),
    .DIN_VALID  (dvi2),
    .DIN_READY  (drdy2),
    .DOUT       (dout2),
    .DOUT_VALID (dvo2),
    .DOUT_READY (dr2),
    .FLUSH      (fl2)
`ifdef SYNC_PIPE_FF_OCC_EN
    ,
    .OCC        (occ2)
`endif
  );

  sync_pipe_ff #(.DATA_W(32), .DEPTH(4)) u_dut4 (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .DIN        (din4),
    .DIN_VALID  (dvi4),
    .DIN_READY  (drdy4),
    .DOUT       (dout4),
    .DOUT_VALID (dvo4),
    .DOUT_READY (dr4),
    .FLUSH      (fl4)
`ifdef SYNC_PIPE_FF_OCC_EN
    ,
    .OCC        (occ4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitors: every DOUT handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && dvo2 && dr2) begin
      if (q2.size() == 0) chk("dout2_unexpected", dout2, 32'hDEAD_BEEF);
      else                chk("dout2", dout2, q2.pop_front());
    end
    if (rst_n && dvo4 && dr4) begin
      if (q4.size() == 0) chk("dout4_unexpected", dout4, 32'hDEAD_BEEF);
      else                chk("dout4", dout4, q4.pop_front());
    end
  end

  // One clock of stimulus; called and returns at posedge+1.
  task automatic cyc2(input logic v, input logic [31:0] d, input logic r,
                      input logic f, input logic exp_rdy, input string nm);
    dvi2 = v; din2 = d; dr2 = r; fl2 = f;
    @(negedge clk);
    chk({nm, "_din_ready"}, {31'd0, drdy2}, {31'd0, exp_rdy});
    if (v && exp_rdy) q2.push_back(d);
    if (f) begin
      #1;
      q2.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc4(input logic v, input logic [31:0] d, input logic r,
                      input logic f, input logic exp_rdy, input string nm);
    dvi4 = v; din4 = d; dr4 = r; fl4 = f;
    @(negedge clk);
    chk({nm, "_din_ready"}, {31'd0, drdy4}, {31'd0, exp_rdy});
    if (v && exp_rdy) q4.push_back(d);
    if (f) begin
      #1;
      q4.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    din2 = '0; dvi2 = 1'b0; dr2 = 1'b0; fl2 = 1'b0;
    din4 = '0; dvi4 = 1'b0; dr4 = 1'b0; fl4 = 1'b0;
    #1;
    chk("rst_dout2",       dout2, 32'd0);
    chk("rst_dvalid2",     {31'd0, dvo2}, 32'd0);
    chk("rst_din_ready2",  {31'd0, drdy2}, 32'd1);
    chk("rst_dout4",       dout4, 32'd0);
    chk("rst_dvalid4",     {31'd0, dvo4}, 32'd0);
`ifdef SYNC_PIPE_FF_OCC_EN
    chk("rst_occ2", {30'd0, occ2}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stream 1..8 through DEPTH=2 with the sink always ready.
    for (int i = 1; i <= 8; i++) begin
      cyc2(1'b1, 32'(i), 1'b1, 1'b0, 1'b1, "stream");
      if (i == 1) chk("lat_dvalid_c1", {31'd0, dvo2}, 32'd0);
      if (i == 2) begin
        chk("lat_dvalid_c2", {31'd0, dvo2}, 32'd1);
        chk("lat_dout_c2",   dout2, 32'h1);
      end
    end
    repeat (3) cyc2(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, "drain1");
    chk("stream_drained", 32'(q2.size()), 32'd0);

    // Fill under backpressure, then push and pop in the same cycle.
    cyc2(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, "fillA");
    cyc2(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, "fillB");
    cyc2(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, "full_stall");
    chk("full_dout",   dout2, 32'hA);
    chk("full_dvalid", {31'd0, dvo2}, 32'd1);
`ifdef SYNC_PIPE_FF_OCC_EN
    chk("full_occ", {30'd0, occ2}, 32'd2);
`endif
    cyc2(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, "push_pop");
    chk("push_pop_dout", dout2, 32'hB);
`ifdef SYNC_PIPE_FF_OCC_EN
    chk("push_pop_occ", {30'd0, occ2}, 32'd2);
`endif
    repeat (3) cyc2(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, "drain2");
    chk("fill_drained", 32'(q2.size()), 32'd0);

    // Flush while a DOUT handshake happens: that word counts as consumed.
    cyc2(1'b1, 32'h61, 1'b0, 1'b0, 1'b1, "fl_fill1");
    cyc2(1'b1, 32'h62, 1'b0, 1'b0, 1'b1, "fl_fill2");
    cyc2(1'b1, 32'h63, 1'b1, 1'b1, 1'b0, "flush2");
    chk("flush2_dvalid", {31'd0, dvo2}, 32'd0);
    repeat (3) cyc2(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, "post_flush2");

    // DEPTH=4: pattern 1,0,1 under stall; the bubble is squeezed out.
    cyc4(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, "bub1");
    cyc4(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, "bub0");
    cyc4(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, "bub2");
`ifdef SYNC_PIPE_FF_OCC_EN
    chk("bubble_occ", {29'd0, occ4}, 32'd2);
`endif
    cyc4(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "bub_idle1");
    cyc4(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "bub_idle2");
    chk("bubble_head_valid", {31'd0, dvo4}, 32'd1);
    chk("bubble_head_dout",  dout4, 32'h11);
    cyc4(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "bub_rel1");
    chk("b2b_valid", {31'd0, dvo4}, 32'd1);
    chk("b2b_dout",  dout4, 32'h22);
    repeat (4) cyc4(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "bub_drain");
    chk("bubble_drained", 32'(q4.size()), 32'd0);

    // DEPTH=4: flush with three words held and DIN_VALID high.
    cyc4(1'b1, 32'h31, 1'b0, 1'b0, 1'b1, "f31");
    cyc4(1'b1, 32'h32, 1'b0, 1'b0, 1'b1, "f32");
    cyc4(1'b1, 32'h33, 1'b0, 1'b0, 1'b1, "f33");
`ifdef SYNC_PIPE_FF_OCC_EN
    chk("preflush_occ", {29'd0, occ4}, 32'd3);
`endif
    cyc4(1'b1, 32'h34, 1'b0, 1'b1, 1'b0, "flush4");
    chk("flush4_dvalid", {31'd0, dvo4}, 32'd0);
`ifdef SYNC_PIPE_FF_OCC_EN
    chk("flush4_occ", {29'd0, occ4}, 32'd0);
`endif
    cyc4(1'b1, 32'h35, 1'b1, 1'b0, 1'b1, "after_flush");
    repeat (5) cyc4(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, "flush_drain");
    chk("flush_drained", 32'(q4.size()), 32'd0);

    // Asynchronous reset in the middle of a stream.
    cyc2(1'b1, 32'h51, 1'b1, 1'b0, 1'b1, "rs1");
    cyc2(1'b1, 32'h52, 1'b1, 1'b0, 1'b1, "rs2");
    cyc2(1'b1, 32'h53, 1'b1, 1'b0, 1'b1, "rs3");
    chk("pre_reset_dvalid", {31'd0, dvo2}, 32'd1);
    dvi2 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout",   dout2, 32'd0);
    chk("async_rst_dvalid", {31'd0, dvo2}, 32'd0);
    q2.delete();
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_din_ready", {31'd0, drdy2}, 32'd1);
    chk("post_reset_dvalid",    {31'd0, dvo2}, 32'd0);
    repeat (3) cyc2(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_pipe_ff.md
Name: sync_pipe_ff

Overview:
- Parametrised successor to the single-flop register stage: a DEPTH-stage elastic register pipeline of DATA_W-bit words with valid/ready flow control.
- Each stage carries a valid bit. Empty stages collapse (bubble-squashing), so backpressure never loses or duplicates data.
- Used as a timing-break / retiming pipe between datapath blocks in the CLK domain.
- Provides a synchronous FLUSH; the same module serves fixed-latency pipes and stallable ones.

Parameters:
- DATA_W, 32, payload width in bits (>=1)
- DEPTH, 2, number of register stages (>=1; DEPTH=1 is a single elastic register)

Ports:
- CLK  input  1  clock
- RESET_N  input  1  reset, asynchronous, active-low
- DIN  input  DATA_W  input payload
- DIN_VALID  input  1  DIN holds a word
- DIN_READY  output  1  pipe accepts DIN this cycle
- DOUT  output  DATA_W  payload of last stage
- DOUT_VALID  output  1  DOUT holds a word
- DOUT_READY  input  1  downstream consumes DOUT this cycle
- FLUSH  input  1  synchronous discard of all stored words
- OCC  output  $clog2(DEPTH+1)  stage occupancy; present only with SYNC_PIPE_FF_OCC_EN

Behaviour:
- Reset (RESET_N low, async):
  - all stage valids = 0; all stage data = 0
  - DOUT = 0, DOUT_VALID = 0, OCC = 0
- Stage i has registers v[i] and d[i]. Stage DEPTH-1 drives DOUT/DOUT_VALID.
- Ready chain (combinational):
  - rdy[DEPTH] = DOUT_READY
  - rdy[i] = !v[i] || rdy[i+1]
  - DIN_READY = rdy[0] && !FLUSH
- Transfer into stage i occurs when rdy[i] is high:
  - v[i] <= source valid, where the source is DIN_VALID for i=0, else v[i-1]
  - d[i] <= source data only when source valid = 1; otherwise d[i] holds (no toggling on bubbles)
- When rdy[i] is low, stage i holds both v and d.
- Latency: DIN to DOUT is exactly DEPTH cycles with DOUT_READY held high.
- Throughput: 1 word/cycle sustained.
- Full pipe with DOUT_READY=0:
  - DIN_READY = 0; contents frozen
  - words leave in order once DOUT_READY=1
- Simultaneous pop and push on a full pipe: DOUT_READY=1 with DIN_VALID=1 advances everything and accepts the new word the same cycle (DIN_READY=1).
- Bubbles: a gap in DIN_VALID propagates as v=0. A downstream stall lets upstream words fill the empty stages.
- FLUSH=1 has priority over all transfers:
  - next cycle all v[i] = 0
  - d[i] hold
  - DIN not accepted (DIN_READY=0)
  - a DOUT handshake in the flush cycle is still counted as consumed by downstream
- DOUT_VALID, once high, stays high with stable DOUT until DOUT_READY=1 or FLUSH.
- Reset asserted mid-transfer: all contents are lost immediately. The first DIN_READY after release = 1.

Optional Feature:
- Macro: SYNC_PIPE_FF_OCC_EN
- Defined:
  - OCC port present; registered count of set v[i]
  - updates as: +1 on accepted DIN, -1 on DOUT handshake, net 0 when both occur
  - cleared to 0 by FLUSH and by reset
  - range 0..DEPTH
- Undefined: OCC port and counter logic absent; all other behaviour identical.

Decomposition:
- Package sync_pkg holds:
  - function occ_w(depth) returning $clog2(depth+1), with a minimum of 1
  - constant SYNC_PIPE_MAX_DEPTH = 64; elaboration-time check DEPTH in 1..64
- Natural sub-module: sync_pipe_stage, one elastic stage (v/d registers, rdy_in/rdy_out), instantiated DEPTH times in a generate loop.

Test Plan:
- Reset then stream 0x1..0x8, DEPTH=2, DOUT_READY=1 -> DOUT_VALID rises 2 cycles after first accept; outputs 0x1..0x8 in order, one per cycle.
- Fill with 0xA,0xB while DOUT_READY=0 -> DIN_READY=0 after 2 accepts; OCC=2; DOUT stable at 0xA; after DOUT_READY=1 -> 0xA then 0xB.
- Full pipe, DIN_VALID=1 with 0xC and DOUT_READY=1 the same cycle -> 0xA popped and 0xC accepted; OCC stays 2.
- DIN_VALID pattern 1,0,1 with DOUT_READY=0 for 3 cycles, DEPTH=4 -> bubble collapses; OCC=2; words emerge back-to-back.
- FLUSH asserted with OCC=3, DIN_VALID=1 -> DIN_READY=0 that cycle; next cycle DOUT_VALID=0, OCC=0; the following DIN accepted normally.
- RESET_N pulsed low asynchronously mid-stream -> DOUT=0, DOUT_VALID=0 immediately; DIN_READY=1 after release.
